// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings,
// default reset vector and the word-alignment helper.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IF_RESET = 2'd0,
        IF_FETCH = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned IF_ENTRY_W       = 64;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response, redirect
// input from execute and the {instr, pc} handoff to decode.
interface inst_fetch_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// In-order fetch buffer holding {pc, instr}; flush empties it and overrides
// any same-cycle push or pop. Head is visible one cycle after the push.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = IF_ENTRY_W,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is dropped unless the head leaves the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC ownership, credit-limited request issue,
// in-order response capture and redirect flushing.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    inst_fetch_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    if_state_e     r_state;
    if_state_e     w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_outstanding_next;
    logic [CW-1:0] w_discard_next;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic [63:0]   w_head;

    logic [31:0]   w_target;
    logic          w_redirect;
    logic          w_pop;
    logic          w_push;
    logic          w_accept;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic          w_req_valid;
    logic [SW-1:0] w_credit_used;

    assign w_target   = align_word(bus.redirect_pc);
    assign w_redirect = bus.redirect_valid && (r_state != IF_RESET);
    assign w_pop      = !w_empty && bus.if_ready;
    assign w_rsp_keep = bus.imem_rsp_valid && (r_discard == '0);
    assign w_rsp_drop = bus.imem_rsp_valid && (r_discard != '0);
    assign w_push     = w_rsp_keep && !w_redirect;
    assign w_accept   = w_req_valid && bus.imem_req_ready;

    // Buffered plus in-flight words may never exceed the buffer depth, so a
    // returning response always finds a free slot.
    assign w_credit_used      = SW'(w_count) + SW'(r_outstanding) - SW'(w_pop);
    assign w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(bus.imem_rsp_valid);

    always_comb begin
        w_state_next   = r_state;
        w_req_valid    = 1'b0;
        w_discard_next = r_discard;
        if (w_rsp_drop) w_discard_next = r_discard - 1'b1;
        case (r_state)
            IF_RESET: w_state_next = IF_FETCH;
            IF_FETCH: w_req_valid  = !w_redirect && (w_credit_used < SW'(DEPTH));
            IF_FLUSH: if (w_discard_next == '0) w_state_next = IF_FETCH;
            default:  w_state_next = IF_RESET;
        endcase
        // Everything still in flight after this edge belongs to the old path.
        if (w_redirect) begin
            w_discard_next = w_outstanding_next;
            w_state_next   = (w_outstanding_next != '0) ? IF_FLUSH : IF_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IF_RESET;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;
            if (w_redirect) begin
                r_pc     <= w_target;
                r_rsp_pc <= w_target;
            end else begin
                if (w_accept)   r_pc     <= r_pc + 32'd4;
                if (w_rsp_keep) r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

    inst_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IF_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  ({r_rsp_pc, bus.imem_rsp_data}),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = !w_empty;
    assign bus.if_instr       = w_empty ? 32'h0 : w_head[31:0];
    assign bus.if_pc          = w_empty ? 32'h0 : w_head[63:32];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with an in-order instruction memory model
// of programmable latency; checks are immediate assertions at each step.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   lat      = 1;
    int   cyc      = 0;

    logic [31:0] q_addr [$];
    int          q_due  [$];

    inst_fetch_if bus();

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Memory: record accepted requests at the edge, answer in order later.
    always @(posedge clk) begin
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            q_addr.push_back(bus.imem_req_addr);
            q_due.push_back(cyc + lat);
        end
        cyc++;
    end

    always @(negedge clk) begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (rst_n && q_addr.size() > 0 && q_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(q_addr.pop_front());
            void'(q_due.pop_front());
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dut.w_push && !dut.w_pop && dut.w_count == DEPTH))
            else begin
                n_fails++;
                $error("FAIL push_into_full: count=%0d", dut.w_count);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        step(1);
        rst_n = 1'b1;
        #1;
        chk("reset_cycle_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;

        // Reset values
        step(1);
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("rst_req_addr",  bus.imem_req_addr, 32'h0);
        chk("rst_if_valid",  {31'b0, bus.if_valid}, 32'h0);
        chk("rst_if_instr",  bus.if_instr, 32'h0);
        chk("rst_if_pc",     bus.if_pc, 32'h0);
        release_reset();

        // Streaming with 1-cycle memory
        step(1);
        chk("t1_req_valid0", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("t1_req_addr0",  bus.imem_req_addr, 32'h0);
        chk("t1_if_valid_n1", {31'b0, bus.if_valid}, 32'h0);
        step(1);
        chk("t1_req_addr1",  bus.imem_req_addr, 32'h4);
        chk("t1_if_valid_n2", {31'b0, bus.if_valid}, 32'h0);
        step(1);
        chk("t1_if_valid_n3", {31'b0, bus.if_valid}, 32'h1);
        chk("t1_if_pc0",     bus.if_pc, 32'h0);
        chk("t1_if_instr0",  bus.if_instr, mem_word(32'h0));
        chk("t1_req_addr2",  bus.imem_req_addr, 32'h8);
        step(1);
        chk("t1_if_pc1",     bus.if_pc, 32'h4);
        chk("t1_if_instr1",  bus.if_instr, mem_word(32'h4));
        step(1);
        chk("t1_if_pc2",     bus.if_pc, 32'h8);

        // Backpressure from decode
        bus.if_ready = 1'b0;
        step(1);
        chk("t2_req_stall",  {31'b0, bus.imem_req_valid}, 32'h0);
        chk("t2_head_hold",  bus.if_pc, 32'h8);
        step(2);
        chk("t2_req_stall2", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("t2_addr_hold",  bus.imem_req_addr, 32'h10);
        chk("t2_full_count", {30'b0, dut.w_count}, 32'h2);
        bus.if_ready = 1'b1;
        #1;
        chk("t2_req_resume", {31'b0, bus.imem_req_valid}, 32'h1);
        step(1);
        chk("t2_drain_pc_c",  bus.if_pc, 32'hC);
        chk("t2_req_addr_14", bus.imem_req_addr, 32'h14);
        step(1);
        chk("t2_drain_pc_10", bus.if_pc, 32'h10);
        step(1);
        chk("t2_drain_pc_14", bus.if_pc, 32'h14);
        chk("t2_instr_14",    bus.if_instr, mem_word(32'h14));

        // 3-cycle memory, redirect with two requests in flight
        rst_n = 1'b0;
        lat   = 3;
        release_reset();
        step(2);
        chk("t3_req_addr4", bus.imem_req_addr, 32'h4);
        step(1);
        chk("t3_credit_stall", {31'b0, bus.imem_req_valid}, 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        chk("t3_redir_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        step(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_state_flush", 32'(dut.r_state), 32'(IF_FLUSH));
        chk("t3_flush_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("t3_flush_addr",   bus.imem_req_addr, 32'h100);
        step(1);
        chk("t3_drop1_if_valid", {31'b0, bus.if_valid}, 32'h0);
        chk("t3_drop1_no_req",   {31'b0, bus.imem_req_valid}, 32'h0);
        step(1);
        chk("t3_refetch_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("t3_refetch_addr",  bus.imem_req_addr, 32'h100);
        chk("t3_drop2_if_valid", {31'b0, bus.if_valid}, 32'h0);
        step(3);
        chk("t3_not_yet_valid", {31'b0, bus.if_valid}, 32'h0);
        step(1);
        chk("t3_first_valid", {31'b0, bus.if_valid}, 32'h1);
        chk("t3_first_pc",    bus.if_pc, 32'h100);
        chk("t3_first_instr", bus.if_instr, mem_word(32'h100));

        // Redirect coinciding with a response and a pop
        rst_n = 1'b0;
        lat   = 1;
        release_reset();
        step(3);
        chk("t4_pre_head_pc", bus.if_pc, 32'h0);
        chk("t4_pre_rsp",     {31'b0, bus.imem_rsp_valid}, 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        chk("t4_redir_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        step(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_flushed_valid", {31'b0, bus.if_valid}, 32'h0);
        chk("t4_flushed_pc",    bus.if_pc, 32'h0);
        chk("t4_req_addr",      bus.imem_req_addr, 32'h40);
        chk("t4_req_valid",     {31'b0, bus.imem_req_valid}, 32'h1);
        step(1);
        chk("t4_no_stale",      {31'b0, bus.if_valid}, 32'h0);
        step(1);
        chk("t4_target_pc",     bus.if_pc, 32'h40);
        chk("t4_target_instr",  bus.if_instr, mem_word(32'h40));

        // PC wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        #1;
        step(1);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t5_req_top",     bus.imem_req_addr, 32'hFFFF_FFFC);
        chk("t5_flushed",     {31'b0, bus.if_valid}, 32'h0);
        step(1);
        chk("t5_req_wrap",    bus.imem_req_addr, 32'h0);
        chk("t5_req_wrap_v",  {31'b0, bus.imem_req_valid}, 32'h1);
        step(1);
        chk("t5_pc_top",      bus.if_pc, 32'hFFFF_FFFC);
        chk("t5_instr_top",   bus.if_instr, mem_word(32'hFFFF_FFFC));
        step(1);
        chk("t5_pc_wrapped",  bus.if_pc, 32'h0);

        // Reset with the buffer full
        bus.if_ready = 1'b0;
        step(2);
        chk("t6_full_valid",  {31'b0, bus.if_valid}, 32'h1);
        chk("t6_full_stall",  {31'b0, bus.imem_req_valid}, 32'h0);
        chk("t6_full_count",  {30'b0, dut.w_count}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_if_valid",  {31'b0, bus.if_valid}, 32'h0);
        chk("t6_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        chk("t6_rst_req_addr",  bus.imem_req_addr, 32'h0);
        chk("t6_rst_if_pc",     bus.if_pc, 32'h0);
        chk("t6_rst_if_instr",  bus.if_instr, 32'h0);
        bus.if_ready = 1'b1;
        release_reset();
        step(1);
        chk("t6_restart_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("t6_restart_addr",  bus.imem_req_addr, 32'h0);
        step(2);
        chk("t6_restart_pc",    bus.if_pc, 32'h0);
        chk("t6_restart_instr", bus.if_instr, mem_word(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
